// File: rtl/ahbl_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahbl_arbiter_pkg: shared AHB-lite encodings for the arbiter slice.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahbl_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // hwrite + hsize + hburst + hprot + hmaster + hmastlock + hexcl
  localparam int C_W_ATTR_FIXED = 1 + 3 + 3 + 4 + 8 + 1 + 1;

endpackage
`default_nettype wire

// File: rtl/onehot_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onehot_mux: AND-OR multiplexer; an all-zero select yields zero.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout = dout | ({W{sel[i]}} & din[i*W +: W]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahbl_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahbl_arbiter: N-master to 1-slave AHB-lite fixed-priority arbiter    |
// | with per-port address-phase buffering and locked-transfer support.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahbl_arbiter
  import ahbl_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          src_hready,
  output logic [N_PORTS-1:0]          src_hready_resp,
  output logic [N_PORTS-1:0]          src_hresp,
  output logic [N_PORTS-1:0]          src_hexokay,
  input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
  input  logic [N_PORTS*2-1:0]        src_htrans,
  input  logic [N_PORTS-1:0]          src_hwrite,
  input  logic [N_PORTS*3-1:0]        src_hsize,
  input  logic [N_PORTS*3-1:0]        src_hburst,
  input  logic [N_PORTS*4-1:0]        src_hprot,
  input  logic [N_PORTS*8-1:0]        src_hmaster,
  input  logic [N_PORTS-1:0]          src_hmastlock,
  input  logic [N_PORTS-1:0]          src_hexcl,
  input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
  output logic [N_PORTS*W_DATA-1:0]   src_hrdata,
  output logic                        dst_hready,
  input  logic                        dst_hready_resp,
  input  logic                        dst_hresp,
  input  logic                        dst_hexokay,
  output logic [W_ADDR-1:0]           dst_haddr,
  output logic [1:0]                  dst_htrans,
  output logic                        dst_hwrite,
  output logic [2:0]                  dst_hsize,
  output logic [2:0]                  dst_hburst,
  output logic [3:0]                  dst_hprot,
  output logic [7:0]                  dst_hmaster,
  output logic                        dst_hmastlock,
  output logic                        dst_hexcl,
  output logic [W_DATA-1:0]           dst_hwdata,
  input  logic [W_DATA-1:0]           dst_hrdata
);

  localparam int C_W_ATTR = W_ADDR + C_W_ATTR_FIXED;

  logic [N_PORTS-1:0]          w_live;
  logic [N_PORTS-1:0]          w_cand;
  logic [N_PORTS-1:0]          w_elig;
  logic [N_PORTS-1:0]          w_grant;
  logic                        w_found;
  logic [N_PORTS*C_W_ATTR-1:0] w_live_attr;
  logic [N_PORTS*C_W_ATTR-1:0] w_cand_attr;
  logic [C_W_ATTR-1:0]         w_dst_attr;
  logic [N_PORTS-1:0]          w_unused_htrans_lsb;

  logic [N_PORTS-1:0]          r_buf_valid;
  logic [C_W_ATTR-1:0]         r_buf_attr [N_PORTS];
  logic [N_PORTS-1:0]          r_grant_d;
  logic                        r_lock;
  logic [N_PORTS-1:0]          r_lock_owner;

  generate
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
      assign w_live[i] = src_hready[i] && src_htrans[2*i+1];
      assign w_unused_htrans_lsb[i] = src_htrans[2*i];
      assign w_live_attr[i*C_W_ATTR +: C_W_ATTR] = {
        src_haddr[i*W_ADDR +: W_ADDR], src_hwrite[i], src_hsize[3*i +: 3],
        src_hburst[3*i +: 3], src_hprot[4*i +: 4], src_hmaster[8*i +: 8],
        src_hmastlock[i], src_hexcl[i]};

      // A buffered request shadows the live bus; gating with rst_n keeps the slave idle in reset.
      assign w_cand[i] = rst_n && (r_buf_valid[i] || w_live[i]);
      assign w_cand_attr[i*C_W_ATTR +: C_W_ATTR] =
        r_buf_valid[i] ? r_buf_attr[i] : w_live_attr[i*C_W_ATTR +: C_W_ATTR];

      assign src_hready_resp[i] = r_grant_d[i] ? dst_hready_resp : !r_buf_valid[i];
      assign src_hresp[i]       = r_grant_d[i] && dst_hresp;
      assign src_hexokay[i]     = r_grant_d[i] && dst_hexokay;
      assign src_hrdata[i*W_DATA +: W_DATA] = dst_hrdata;
    end
  endgenerate

  always_comb begin
    w_elig  = r_lock ? (w_cand & r_lock_owner) : w_cand;
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_elig[i] && !w_found) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  onehot_mux #(.N(N_PORTS), .W(C_W_ATTR)) u_attr_mux (
    .sel  (w_grant),
    .din  (w_cand_attr),
    .dout (w_dst_attr)
  );

  onehot_mux #(.N(N_PORTS), .W(W_DATA)) u_wdata_mux (
    .sel  (r_grant_d),
    .din  (src_hwdata),
    .dout (dst_hwdata)
  );

  assign {dst_haddr, dst_hwrite, dst_hsize, dst_hburst, dst_hprot,
          dst_hmaster, dst_hmastlock, dst_hexcl} = w_dst_attr;
  assign dst_htrans = (|w_grant) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign dst_hready = dst_hready_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid  <= '0;
      r_grant_d    <= '0;
      r_lock       <= 1'b0;
      r_lock_owner <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_grant[i] && dst_hready) begin
          r_buf_valid[i] <= 1'b0;
        end else if (w_live[i] && !r_buf_valid[i]) begin
          r_buf_valid[i] <= 1'b1;
        end
      end
      // Lock follows the address phase actually handed to the slave; an IDLE phase releases it.
      if (dst_hready) begin
        r_grant_d    <= w_grant;
        r_lock       <= dst_hmastlock && (|w_grant);
        r_lock_owner <= w_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_live[i] && !r_buf_valid[i]) begin
        r_buf_attr[i] <= w_live_attr[i*C_W_ATTR +: C_W_ATTR];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahbl_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahbl_arbiter: directed self-checking bench for ahbl_arbiter.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ahbl_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  src_hready;
  logic [1:0]  src_hready_resp, src_hresp, src_hexokay;
  logic [63:0] src_haddr = '0;
  logic [3:0]  src_htrans = '0;
  logic [1:0]  src_hwrite = '0;
  logic [5:0]  src_hsize = {3'd2, 3'd2};
  logic [5:0]  src_hburst = '0;
  logic [7:0]  src_hprot = '0;
  logic [15:0] src_hmaster = {8'd1, 8'd0};
  logic [1:0]  src_hmastlock = '0;
  logic [1:0]  src_hexcl = '0;
  logic [63:0] src_hwdata = '0;
  logic [63:0] src_hrdata;
  logic        dst_hready;
  logic        dst_hready_resp = 1'b1;
  logic        dst_hresp = 1'b0;
  logic        dst_hexokay = 1'b0;
  logic [31:0] dst_haddr;
  logic [1:0]  dst_htrans;
  logic        dst_hwrite;
  logic [2:0]  dst_hsize, dst_hburst;
  logic [3:0]  dst_hprot;
  logic [7:0]  dst_hmaster;
  logic        dst_hmastlock, dst_hexcl;
  logic [31:0] dst_hwdata;
  logic [31:0] dst_hrdata = '0;

  int total = 0;
  int bad = 0;

  assign src_hready = src_hready_resp;

  always #5 clk = ~clk;

  ahbl_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp),
    .src_hresp(src_hresp), .src_hexokay(src_hexokay),
    .src_haddr(src_haddr), .src_htrans(src_htrans), .src_hwrite(src_hwrite),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmaster(src_hmaster), .src_hmastlock(src_hmastlock), .src_hexcl(src_hexcl),
    .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp),
    .dst_hresp(dst_hresp), .dst_hexokay(dst_hexokay),
    .dst_haddr(dst_haddr), .dst_htrans(dst_htrans), .dst_hwrite(dst_hwrite),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmaster(dst_hmaster), .dst_hmastlock(dst_hmastlock), .dst_hexcl(dst_hexcl),
    .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int p, input logic [1:0] tr, input logic [31:0] a,
                     input logic wr, input logic lk);
    src_htrans[2*p +: 2]  = tr;
    src_haddr[32*p +: 32] = a;
    src_hwrite[p]         = wr;
    src_hmastlock[p]      = lk;
  endtask

  task automatic idle_all();
    src_htrans    = '0;
    src_hmastlock = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    cyc();
    #2;
    chk("rst_htrans", dst_htrans, 2'b00);
    chk("rst_hready_resp", src_hready_resp, 2'b11);
    chk("rst_hresp", src_hresp, 2'b00);
    chk("rst_hexokay", src_hexokay, 2'b00);
    chk("rst_hwdata", dst_hwdata, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // lone request on port1
    drv(1, 2'b10, 32'h100, 1'b0, 1'b0);
    #2;
    chk("lone_htrans", dst_htrans, 2'b10);
    chk("lone_haddr", dst_haddr, 32'h100);
    chk("lone_hwrite", dst_hwrite, 1'b0);
    chk("lone_hsize", dst_hsize, 3'd2);
    chk("lone_hmaster", dst_hmaster, 8'd1);
    cyc();
    idle_all();
    dst_hready_resp = 1'b0;
    dst_hexokay     = 1'b1;
    dst_hrdata      = 32'hCAFE_0001;
    #2;
    chk("lone_stall_resp", src_hready_resp, 2'b01);
    chk("lone_exokay", src_hexokay, 2'b10);
    chk("lone_idle", dst_htrans, 2'b00);
    chk("lone_hrdata", src_hrdata, 64'hCAFE_0001_CAFE_0001);
    cyc();
    dst_hready_resp = 1'b1;
    dst_hexokay     = 1'b0;
    #2;
    chk("lone_done_resp", src_hready_resp, 2'b11);
    cyc();

    // collision
    drv(0, 2'b10, 32'h10, 1'b1, 1'b0);
    drv(1, 2'b10, 32'h20, 1'b1, 1'b0);
    #2;
    chk("col_haddr0", dst_haddr, 32'h10);
    chk("col_resp0", src_hready_resp, 2'b11);
    cyc();
    idle_all();
    src_hwdata = {32'h0000_BBBB, 32'h0000_AAAA};
    #2;
    chk("col_haddr1", dst_haddr, 32'h20);
    chk("col_htrans1", dst_htrans, 2'b10);
    chk("col_hwdata0", dst_hwdata, 32'hAAAA);
    chk("col_resp1", src_hready_resp, 2'b01);
    cyc();
    #2;
    chk("col_idle", dst_htrans, 2'b00);
    chk("col_hwdata1", dst_hwdata, 32'hBBBB);
    chk("col_resp2", src_hready_resp, 2'b11);
    cyc();

    // slave stall holds a buffered request
    drv(0, 2'b10, 32'h30, 1'b0, 1'b0);
    #2;
    chk("stl_haddr0", dst_haddr, 32'h30);
    cyc();
    idle_all();
    drv(1, 2'b10, 32'h40, 1'b0, 1'b0);
    dst_hready_resp = 1'b0;
    #2;
    chk("stl_haddr1", dst_haddr, 32'h40);
    chk("stl_resp_a", src_hready_resp, 2'b10);
    cyc();
    idle_all();
    #2;
    chk("stl_resp_b", src_hready_resp, 2'b00);
    chk("stl_hold_haddr", dst_haddr, 32'h40);
    cyc();
    #2;
    chk("stl_resp_c", src_hready_resp, 2'b00);
    chk("stl_hold_htrans", dst_htrans, 2'b10);
    cyc();
    dst_hready_resp = 1'b1;
    #2;
    chk("stl_resp_d", src_hready_resp, 2'b01);
    chk("stl_issue", dst_haddr, 32'h40);
    cyc();
    #2;
    chk("stl_resp_e", src_hready_resp, 2'b11);
    chk("stl_idle", dst_htrans, 2'b00);
    cyc();

    // two-cycle error to port1
    drv(1, 2'b10, 32'h50, 1'b1, 1'b0);
    cyc();
    idle_all();
    dst_hready_resp = 1'b0;
    dst_hresp       = 1'b1;
    #2;
    chk("err_hresp_a", src_hresp, 2'b10);
    chk("err_resp_a", src_hready_resp, 2'b01);
    cyc();
    dst_hready_resp = 1'b1;
    #2;
    chk("err_hresp_b", src_hresp, 2'b10);
    chk("err_resp_b", src_hready_resp, 2'b11);
    cyc();
    dst_hresp = 1'b0;
    #2;
    chk("err_hresp_c", src_hresp, 2'b00);
    cyc();

    // lock keeps port1 ahead of a pending port0
    drv(1, 2'b10, 32'h60, 1'b0, 1'b1);
    #2;
    chk("lck_mastlock", dst_hmastlock, 1'b1);
    cyc();
    drv(0, 2'b10, 32'h70, 1'b0, 1'b0);
    drv(1, 2'b10, 32'h64, 1'b0, 1'b1);
    #2;
    chk("lck_win", dst_haddr, 32'h64);
    cyc();
    idle_all();
    drv(1, 2'b11, 32'h68, 1'b0, 1'b0);
    #2;
    chk("lck_seq_addr", dst_haddr, 32'h68);
    chk("lck_seq_promote", dst_htrans, 2'b10);
    chk("lck_resp", src_hready_resp, 2'b10);
    cyc();
    idle_all();
    #2;
    chk("lck_release", dst_haddr, 32'h70);
    cyc();
    #2;
    chk("lck_resp_end", src_hready_resp, 2'b11);
    cyc();

    // reset in the middle of a transfer with port1 buffered
    drv(0, 2'b10, 32'h80, 1'b1, 1'b0);
    drv(1, 2'b10, 32'h90, 1'b1, 1'b0);
    #2;
    chk("mrst_haddr0", dst_haddr, 32'h80);
    cyc();
    idle_all();
    src_hwdata = {32'h0, 32'h1234};
    #2;
    chk("mrst_pre_resp", src_hready_resp, 2'b01);
    chk("mrst_pre_hwdata", dst_hwdata, 32'h1234);
    rst_n = 1'b0;
    #1;
    chk("mrst_htrans", dst_htrans, 2'b00);
    chk("mrst_resp", src_hready_resp, 2'b11);
    chk("mrst_hresp", src_hresp, 2'b00);
    chk("mrst_hexokay", src_hexokay, 2'b00);
    chk("mrst_hwdata", dst_hwdata, 32'h0);
    drv(0, 2'b10, 32'hC0, 1'b0, 1'b0);
    #1;
    chk("mrst_live_idle", dst_htrans, 2'b00);
    cyc();
    idle_all();
    cyc();
    rst_n = 1'b1;
    drv(1, 2'b10, 32'hB0, 1'b0, 1'b0);
    #2;
    chk("post_rst_haddr", dst_haddr, 32'hB0);
    chk("post_rst_htrans", dst_htrans, 2'b10);
    cyc();
    idle_all();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
